// File: rtl/victim_writeback_buffer.sv
// Victim writeback buffer: a small FIFO of dirty lines between the victim
// cache and physical memory. Reads go first (served from the buffer on a
// tag hit), evictions coalesce on a tag match, and buffered lines drain to
// memory whenever no upstream request is waiting.
module victim_writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_read,
  input  logic         up_write,
  input  logic [15:0]  up_address,
  input  logic [127:0] up_wdata,
  output logic [127:0] up_rdata,
  output logic         up_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         buf_empty,
  output logic         buf_full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_HIT,
    RD_MEM,
    WR_ACC,
    DRAIN,
    RESP
  } state_t;

  state_t state, state_next;

  logic [DEPTH-1:0] valid;
  logic [11:0]      tags  [DEPTH];
  logic [127:0]     lines [DEPTH];
  logic [IW-1:0]    head, tail;
  logic [CW-1:0]    count, count_next;
  logic [11:0]      req_tag;
  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic             enq, deq;
  logic             unused_low_bits;

  assign req_tag         = up_address[15:4];
  assign unused_low_bits = ^up_address[3:0];

  // A new entry is appended only when the eviction does not coalesce; an
  // entry leaves only when memory acknowledges the head write.
  assign enq = (state == WR_ACC) && !hit;
  assign deq = (state == DRAIN) && pmem_resp;

  // Tag lookup across valid entries; tags are unique so at most one matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Occupancy after this cycle's enqueue or dequeue (never both at once).
  always_comb begin
    count_next = count;
    if (enq) begin
      count_next = count + 1'b1;
    end else if (deq) begin
      count_next = count - 1'b1;
    end
  end

  // Control state, FIFO pointers, valid bits, status flags and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      buf_empty <= 1'b1;
      buf_full  <= 1'b0;
      up_rdata  <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      buf_empty <= (count_next == '0);
      buf_full  <= (count_next == FULL_COUNT);
      if (enq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (state == RD_HIT) begin
        up_rdata <= lines[hit_idx];
      end else if ((state == RD_MEM) && pmem_resp) begin
        up_rdata <= pmem_rdata;
      end
    end
  end

  // Line storage: merge into a matching entry or append at the tail.
  always_ff @(posedge clk) begin
    if (state == WR_ACC) begin
      if (hit) begin
        lines[hit_idx] <= up_wdata;
      end else begin
        lines[tail] <= up_wdata;
        tags[tail]  <= req_tag;
      end
    end
  end

  // Next-state and memory/upstream handshake outputs.
  always_comb begin
    state_next   = state;
    up_resp      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (up_read) begin
          state_next = hit ? RD_HIT : RD_MEM;
        end else if (up_write) begin
          state_next = (hit || (count != FULL_COUNT)) ? WR_ACC : DRAIN;
        end else if (count != '0) begin
          state_next = DRAIN;
        end
      end
      RD_HIT: begin
        state_next = RESP;
      end
      RD_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, 4'b0000};
        if (pmem_resp) begin
          state_next = RESP;
        end
      end
      WR_ACC: begin
        state_next = RESP;
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[head], 4'b0000};
        pmem_wdata   = lines[head];
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      RESP: begin
        up_resp    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Directed bench for victim_writeback_buffer: a small memory responder with
// a hold switch, a transaction log of what reached memory, and hand-computed
// expectations checked with immediate assertions.
module tb_victim_writeback_buffer;

  localparam logic [127:0] DATA_A = {4{32'hA1A1_A1A1}};
  localparam logic [127:0] DATA_B = {4{32'hB2B2_B2B2}};
  localparam logic [127:0] DATA_C = {4{32'hC3C3_C3C3}};
  localparam logic [127:0] DATA_D = {4{32'hD4D4_D4D4}};
  localparam logic [127:0] DATA_E = {4{32'hE5E5_E5E5}};
  localparam logic [127:0] DATA_F = {4{32'hF6F6_F6F6}};
  localparam logic [127:0] DATA_G = {4{32'h0707_0707}};
  localparam logic [127:0] LINE_1 = {4{32'h1111_0001}};
  localparam logic [127:0] LINE_2 = {4{32'h2222_0002}};
  localparam logic [127:0] LINE_3 = {4{32'h3333_0003}};
  localparam logic [127:0] LINE_4 = {4{32'h4444_0004}};
  localparam logic [127:0] LINE_5 = {4{32'h5555_0005}};
  localparam logic [127:0] MISS_DATA = {8{16'h9990}};
  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         up_read = 1'b0;
  logic         up_write = 1'b0;
  logic [15:0]  up_address = '0;
  logic [127:0] up_wdata = '0;
  logic [127:0] up_rdata;
  logic         up_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic         buf_empty;
  logic         buf_full;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int check_cnt = 0;
  bit mem_hold = 1'b0;
  int read_cycles = 0;
  int snap;

  bit           log_kind [$];
  logic [15:0]  log_addr [$];
  logic [127:0] log_data [$];

  victim_writeback_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_read      (up_read),
    .up_write     (up_write),
    .up_address   (up_address),
    .up_wdata     (up_wdata),
    .up_rdata     (up_rdata),
    .up_resp      (up_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full)
  );

  always #5 clk = ~clk;

  // Memory model: answers after MEM_LAT cycles unless held, logs every
  // completed access (kind 1 = read), returns the address replicated on reads.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (pmem_read) read_cycles++;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end else if ((pmem_read || pmem_write) && !mem_hold) begin
        if (wait_cnt >= MEM_LAT) begin
          wait_cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_read) begin
            pmem_rdata = {8{pmem_address}};
            log_kind.push_back(1'b1);
            log_addr.push_back(pmem_address);
            log_data.push_back({8{pmem_address}});
          end else begin
            log_kind.push_back(1'b0);
            log_addr.push_back(pmem_address);
            log_data.push_back(pmem_wdata);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [127:0] data);
    up_read    = rd;
    up_write   = wr;
    up_address = addr;
    up_wdata   = data;
  endtask

  task automatic waitResp(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!up_resp && n < 200);
    checkOutput(tag, up_resp, 1'b1);
  endtask

  task automatic waitEmpty(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!buf_empty && n < 300);
    checkOutput(tag, buf_empty, 1'b1);
  endtask

  task automatic checkLog(input string tag, input int idx, input bit kind,
                          input logic [15:0] addr, input logic [127:0] data);
    checkOutput({tag, "_present"}, (log_addr.size() > idx), 1'b1);
    if (log_addr.size() > idx) begin
      checkOutput({tag, "_kind"}, log_kind[idx], kind);
      checkOutput({tag, "_addr"}, log_addr[idx], addr);
      checkOutput({tag, "_data"}, log_data[idx], data);
    end
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_up_resp", up_resp, 1'b0);
    checkOutput("rst_pmem_read", pmem_read, 1'b0);
    checkOutput("rst_pmem_write", pmem_write, 1'b0);
    checkOutput("rst_buf_empty", buf_empty, 1'b1);
    checkOutput("rst_buf_full", buf_full, 1'b0);
    checkOutput("rst_up_rdata", up_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single eviction, two-cycle response, then idle drain
    applyStimulus(1'b0, 1'b1, 16'h1230, DATA_A);
    @(negedge clk);
    checkOutput("t1_resp_cycle1", up_resp, 1'b0);
    @(negedge clk);
    checkOutput("t1_resp_cycle2", up_resp, 1'b1);
    checkOutput("t1_not_empty", buf_empty, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitEmpty("t1_drained");
    checkLog("t1_log0", 0, 1'b0, 16'h1230, DATA_A);

    // 2: read hit served from the buffer without touching memory
    applyStimulus(1'b0, 1'b1, 16'h4560, DATA_B);
    waitResp("t2_wr_resp");
    snap = read_cycles;
    applyStimulus(1'b1, 1'b0, 16'h4560, '0);
    waitResp("t2_rd_resp");
    checkOutput("t2_rdata", up_rdata, DATA_B);
    checkOutput("t2_no_pmem_read", read_cycles - snap, 0);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitEmpty("t2_drained");
    checkLog("t2_log1", 1, 1'b0, 16'h4560, DATA_B);

    // 3: fill to DEPTH with memory held, fifth eviction stalls until a drain
    mem_hold = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0010, LINE_1);
    waitResp("t3_wr1_resp");
    applyStimulus(1'b0, 1'b1, 16'h0020, LINE_2);
    waitResp("t3_wr2_resp");
    applyStimulus(1'b0, 1'b1, 16'h0030, LINE_3);
    waitResp("t3_wr3_resp");
    applyStimulus(1'b0, 1'b1, 16'h0040, LINE_4);
    waitResp("t3_wr4_resp");
    checkOutput("t3_full_after4", buf_full, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0050, LINE_5);
    repeat (6) @(negedge clk);
    checkOutput("t3_wr5_stalled", up_resp, 1'b0);
    checkOutput("t3_still_full", buf_full, 1'b1);
    checkOutput("t3_drain_active", pmem_write, 1'b1);
    checkOutput("t3_drain_addr", pmem_address, 16'h0010);
    checkOutput("t3_drain_data", pmem_wdata, LINE_1);
    mem_hold = 1'b0;
    waitResp("t3_wr5_resp");
    checkOutput("t3_full_after5", buf_full, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitEmpty("t3_drained");
    checkLog("t3_log2", 2, 1'b0, 16'h0010, LINE_1);
    checkLog("t3_log5", 5, 1'b0, 16'h0040, LINE_4);
    checkLog("t3_log6", 6, 1'b0, 16'h0050, LINE_5);

    // 4: back-to-back evictions of one line coalesce into one drain
    applyStimulus(1'b0, 1'b1, 16'h7770, DATA_C);
    waitResp("t4_wr1_resp");
    applyStimulus(1'b0, 1'b1, 16'h7770, DATA_D);
    waitResp("t4_wr2_resp");
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitEmpty("t4_drained");
    checkOutput("t4_log_size", log_addr.size(), 8);
    checkLog("t4_log7", 7, 1'b0, 16'h7770, DATA_D);

    // 5: read miss waits for the in-flight drain, then beats the next drain
    mem_hold = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h8880, DATA_E);
    waitResp("t5_wr1_resp");
    applyStimulus(1'b0, 1'b1, 16'h8890, DATA_F);
    waitResp("t5_wr2_resp");
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h9990, '0);
    repeat (4) @(negedge clk);
    checkOutput("t5_drain_held", pmem_write, 1'b1);
    checkOutput("t5_read_waits", pmem_read, 1'b0);
    mem_hold = 1'b0;
    waitResp("t5_rd_resp");
    checkOutput("t5_rdata", up_rdata, MISS_DATA);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitEmpty("t5_drained");
    checkOutput("t5_log_size", log_addr.size(), 11);
    checkLog("t5_log8", 8, 1'b0, 16'h8880, DATA_E);
    checkLog("t5_log9", 9, 1'b1, 16'h9990, MISS_DATA);
    checkLog("t5_log10", 10, 1'b0, 16'h8890, DATA_F);

    // 6: reset in the middle of a drain drops the request and the buffer
    mem_hold = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0A00, DATA_G);
    waitResp("t6_wr_resp");
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    repeat (3) @(negedge clk);
    checkOutput("t6_draining", pmem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_pmem_write", pmem_write, 1'b0);
    checkOutput("t6_rst_buf_empty", buf_empty, 1'b1);
    checkOutput("t6_rst_up_resp", up_resp, 1'b0);
    checkOutput("t6_rst_buf_full", buf_full, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t6_no_drain_after", pmem_write, 1'b0);
    checkOutput("t6_still_empty", buf_empty, 1'b1);
    checkOutput("t6_log_size", log_addr.size(), 11);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
